// File: rtl/servo_seq_pkg.sv
// Shared state type, default travel limits and slew helpers for the servo ramp sequencer.
package servo_seq_pkg;

    localparam int unsigned PosWMax        = 16;
    localparam int unsigned PosMinDefault  = 25;
    localparam int unsigned PosMaxDefault  = 125;
    localparam int unsigned PosInitDefault = 75;

    typedef logic [PosWMax-1:0] pos_t;

    typedef enum logic [0:0] {
        StIdle,
        StSweep
    } seq_state_e;

    function automatic pos_t clamp_pos(pos_t val, pos_t lo, pos_t hi);
        pos_t res;
        if (val < lo) begin
            res = lo;
        end else if (val > hi) begin
            res = hi;
        end else begin
            res = val;
        end
        return res;
    endfunction

    // Differences carry one extra bit so neither direction can underflow.
    function automatic pos_t step_toward(pos_t cur, pos_t tgt, pos_t step);
        logic [PosWMax:0] diff;
        pos_t             res;
        res  = cur;
        diff = '0;
        if (tgt > cur) begin
            diff = {1'b0, tgt} - {1'b0, cur};
            res  = (diff > {1'b0, step}) ? cur + step : tgt;
        end else if (tgt < cur) begin
            diff = {1'b0, cur} - {1'b0, tgt};
            res  = (diff > {1'b0, step}) ? cur - step : tgt;
        end
        return res;
    endfunction

endpackage

// File: rtl/servo_frame_timer.sv
// Free-running PWM frame counter; frame_tick marks the last cycle of each frame.
module servo_frame_timer #(
    parameter int unsigned PERIOD_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    output logic frame_tick
);

    localparam int unsigned CntW = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(PERIOD_CYCLES - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        frame_tick = (cnt_q == CntLast);
        cnt_d      = frame_tick ? '0 : cnt_q + CntW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/servo_ramp_sequencer.sv
// Per-frame slew limiter for servo duty codes with a valid/ready command port.
// Define SERVO_WDOG_EN to add a no-command watchdog that sends all joints home.
module servo_ramp_sequencer
    import servo_seq_pkg::*;
#(
    parameter int unsigned NUM_CH        = 4,
    parameter int unsigned POS_W         = 8,
    parameter int unsigned PERIOD_CYCLES = 1_000_000,
    parameter int unsigned STEP          = 1,
    parameter int unsigned POS_MIN       = PosMinDefault,
    parameter int unsigned POS_MAX       = PosMaxDefault,
    parameter int unsigned POS_INIT      = PosInitDefault
`ifdef SERVO_WDOG_EN
    ,
    parameter int unsigned WDOG_FRAMES   = 200
`endif
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [$clog2(NUM_CH)-1:0] cmd_chan,
    input  logic [POS_W-1:0]          cmd_pos,
    input  logic                      cmd_en,
    output logic [NUM_CH*POS_W-1:0]   pos_out,
    output logic [NUM_CH-1:0]         ch_en,
    output logic                      busy,
    output logic                      frame_tick,
    output logic                      cmd_err
`ifdef SERVO_WDOG_EN
    ,
    output logic                      wdog_trip
`endif
);

    localparam int unsigned ChanW = $clog2(NUM_CH);
    localparam logic [POS_W-1:0] PosMin  = POS_W'(POS_MIN);
    localparam logic [POS_W-1:0] PosMax  = POS_W'(POS_MAX);
    localparam logic [POS_W-1:0] PosInit = POS_W'(POS_INIT);
    localparam logic [ChanW-1:0] LastIdx = ChanW'(NUM_CH - 1);

    seq_state_e        state_q, state_d;
    logic [ChanW-1:0]  idx_q, idx_d;
    logic              live_q;
    logic [POS_W-1:0]  cur_q [NUM_CH];
    logic [POS_W-1:0]  cur_d [NUM_CH];
    logic [POS_W-1:0]  tgt_q [NUM_CH];
    logic [POS_W-1:0]  tgt_d [NUM_CH];
    logic [NUM_CH-1:0] en_q, en_d;
    logic              err_q, err_d;
    logic              hs, chan_ok, pos_clamped;
    logic [POS_W-1:0]  cmd_pos_c;

    servo_frame_timer #(
        .PERIOD_CYCLES (PERIOD_CYCLES)
    ) u_frame_timer (
        .clk        (clk),
        .rst        (rst),
        .frame_tick (frame_tick)
    );

    // live_q holds cmd_ready low until the first clock after reset is released.
    assign cmd_ready   = live_q && (state_q == StIdle);
    assign hs          = cmd_valid && cmd_ready;
    assign chan_ok     = 32'(cmd_chan) < NUM_CH;
    assign pos_clamped = (cmd_pos < PosMin) || (cmd_pos > PosMax);
    assign cmd_pos_c   = POS_W'(clamp_pos(pos_t'(cmd_pos), pos_t'(PosMin), pos_t'(PosMax)));

`ifdef SERVO_WDOG_EN
    localparam int unsigned WdW = $clog2(WDOG_FRAMES + 1);

    logic [WdW-1:0] wd_cnt_q, wd_cnt_d;
    logic           wd_fire, trip_q;

    always_comb begin
        wd_cnt_d = wd_cnt_q;
        wd_fire  = 1'b0;
        if (hs) begin
            wd_cnt_d = '0;
        end else if (frame_tick) begin
            if (wd_cnt_q == WdW'(WDOG_FRAMES - 1)) begin
                wd_fire  = 1'b1;
                wd_cnt_d = '0;
            end else begin
                wd_cnt_d = wd_cnt_q + WdW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt_q <= '0;
            trip_q   <= 1'b0;
        end else begin
            wd_cnt_q <= wd_cnt_d;
            trip_q   <= wd_fire;
        end
    end

    assign wdog_trip = trip_q;
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cur_d   = cur_q;
        tgt_d   = tgt_q;
        en_d    = en_q;
        err_d   = err_q;

        unique case (state_q)
            StIdle: begin
                if (frame_tick) begin
                    state_d = StSweep;
                    idx_d   = '0;
                end
            end
            StSweep: begin
                idx_d = idx_q + ChanW'(1);
                if (idx_q == LastIdx) begin
                    state_d = StIdle;
                    idx_d   = '0;
                end
            end
            default: state_d = StIdle;
        endcase

        for (int i = 0; i < NUM_CH; i++) begin
            if (state_q == StSweep && idx_q == ChanW'(i) && en_q[i]) begin
                cur_d[i] = POS_W'(step_toward(pos_t'(cur_q[i]), pos_t'(tgt_q[i]),
                                              pos_t'(STEP)));
            end
`ifdef SERVO_WDOG_EN
            if (wd_fire) begin
                tgt_d[i] = PosInit;
            end
`endif
            if (hs && chan_ok && cmd_chan == ChanW'(i)) begin
                tgt_d[i] = cmd_pos_c;
                en_d[i]  = cmd_en;
                if (!cmd_en) begin
                    cur_d[i] = PosInit;
                end
            end
        end

        if (hs && (!chan_ok || pos_clamped)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            idx_q   <= '0;
            live_q  <= 1'b0;
            en_q    <= '0;
            err_q   <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                cur_q[i] <= PosInit;
                tgt_q[i] <= PosInit;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            live_q  <= 1'b1;
            en_q    <= en_d;
            err_q   <= err_d;
            cur_q   <= cur_d;
            tgt_q   <= tgt_d;
        end
    end

    always_comb begin
        busy = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            busy = busy | (en_q[i] && (cur_q[i] != tgt_q[i]));
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_pos_out
        assign pos_out[g*POS_W +: POS_W] = cur_q[g];
    end

    assign ch_en   = en_q;
    assign cmd_err = err_q;

endmodule

// File: tb/tb_servo_ramp_sequencer.sv
// Directed bench for servo_ramp_sequencer: per-sweep positions come from a scoreboard queue.
module tb_servo_ramp_sequencer;

    localparam int unsigned PER = 20;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid, cmd_ready, cmd_en, busy, frame_tick, cmd_err;
    logic [1:0]  cmd_chan;
    logic [7:0]  cmd_pos;
    logic [31:0] pos_out;
    logic [3:0]  ch_en;

    // Three-channel instance so a nonexistent channel index can be driven.
    logic        c3_valid, c3_ready, c3_en, busy3, tick3, err3;
    logic [1:0]  c3_chan;
    logic [7:0]  c3_pos;
    logic [23:0] pos3;
    logic [2:0]  en3;
`ifdef SERVO_WDOG_EN
    logic        wdog_trip, wdog_trip3;
`endif

    typedef struct {
        int         ch;
        logic [7:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   lows;

    servo_ramp_sequencer #(
        .NUM_CH        (4),
        .POS_W         (8),
        .PERIOD_CYCLES (PER),
        .STEP          (1)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_chan   (cmd_chan),
        .cmd_pos    (cmd_pos),
        .cmd_en     (cmd_en),
        .pos_out    (pos_out),
        .ch_en      (ch_en),
        .busy       (busy),
        .frame_tick (frame_tick),
        .cmd_err    (cmd_err)
`ifdef SERVO_WDOG_EN
        ,
        .wdog_trip  (wdog_trip)
`endif
    );

    servo_ramp_sequencer #(
        .NUM_CH        (3),
        .POS_W         (8),
        .PERIOD_CYCLES (PER),
        .STEP          (1)
    ) u_dut3 (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (c3_valid),
        .cmd_ready  (c3_ready),
        .cmd_chan   (c3_chan),
        .cmd_pos    (c3_pos),
        .cmd_en     (c3_en),
        .pos_out    (pos3),
        .ch_en      (en3),
        .busy       (busy3),
        .frame_tick (tick3),
        .cmd_err    (err3)
`ifdef SERVO_WDOG_EN
        ,
        .wdog_trip  (wdog_trip3)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_tick();
        int k = 0;
        while (frame_tick !== 1'b1 && k < 2 * PER) begin
            cyc(1);
            k++;
        end
        check("tick_seen", frame_tick, 1);
    endtask

    // Tick edge enters SWEEP, then four edges update channels 0..3.
    task automatic sweep_done();
        wait_tick();
        cyc(5);
    endtask

    task automatic run_sweeps(input int n, input string tag);
        exp_t e;
        for (int s = 0; s < n; s++) begin
            sweep_done();
            if (sb.size() == 0) begin
                check("sb_underflow", 0, 1);
            end else begin
                e = sb.pop_front();
                check(tag, pos_out[e.ch*8 +: 8], e.val);
            end
        end
    endtask

    task automatic send_cmd(input logic [1:0] ch, input logic [7:0] pos, input logic en);
        int k = 0;
        cmd_chan  = ch;
        cmd_pos   = pos;
        cmd_en    = en;
        cmd_valid = 1'b1;
        while (cmd_ready !== 1'b1 && k < 2 * PER) begin
            cyc(1);
            k++;
        end
        check("cmd_ready_seen", cmd_ready, 1);
        cyc(1);
        cmd_valid = 1'b0;
    endtask

    task automatic send3(input logic [1:0] ch, input logic [7:0] pos, input logic en);
        int k = 0;
        c3_chan  = ch;
        c3_pos   = pos;
        c3_en    = en;
        c3_valid = 1'b1;
        while (c3_ready !== 1'b1 && k < 2 * PER) begin
            cyc(1);
            k++;
        end
        check("d3_ready_seen", c3_ready, 1);
        cyc(1);
        c3_valid = 1'b0;
    endtask

    initial begin
        cmd_valid = 1'b0; cmd_chan = '0; cmd_pos = '0; cmd_en = 1'b0;
        c3_valid  = 1'b0; c3_chan  = '0; c3_pos  = '0; c3_en  = 1'b0;
        rst = 1'b1;
        cyc(3);

        // Reset values, ready rises one clock after release, idle frames change nothing
        check("rst_pos", pos_out, 32'h4B4B_4B4B);
        check("rst_en", ch_en, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", cmd_ready, 0);
        check("rst_tick", frame_tick, 0);
        check("rst_err", cmd_err, 0);
        check("d3_rst_tick", tick3, 0);
        rst = 1'b0;
        check("ready_at_release", cmd_ready, 0);
        cyc(1);
        check("ready_after_release", cmd_ready, 1);
        for (int f = 0; f < 3; f++) sweep_done();
        check("idle_pos", pos_out, 32'h4B4B_4B4B);
        check("idle_en", ch_en, 0);
        check("idle_busy", busy, 0);

        // Nonexistent channel on the 3-channel instance
        check("d3_err_init", err3, 0);
        send3(2'd3, 8'd100, 1'b1);
        check("d3_err_badchan", err3, 1);
        check("d3_pos", pos3, 24'h4B_4B4B);
        check("d3_en", en3, 0);
        check("d3_busy", busy3, 0);

        // Ramp channel 1 to 80
        send_cmd(2'd1, 8'd80, 1'b1);
        check("s2_en", ch_en, 4'b0010);
        check("s2_busy", busy, 1);
        check("s2_err", cmd_err, 0);
        for (int k = 1; k <= 5; k++) sb.push_back('{ch: 1, val: 8'(75 + k)});
        sb.push_back('{ch: 1, val: 8'd80});
        run_sweeps(4, "s2_ramp");
        check("s2_busy_mid", busy, 1);
        run_sweeps(1, "s2_ramp");
        check("s2_busy_done", busy, 0);
        run_sweeps(1, "s2_hold");

        // Out-of-range duty code is clamped to the upper limit
        send_cmd(2'd2, 8'd200, 1'b1);
        check("s3_err", cmd_err, 1);
        check("s3_en", ch_en, 4'b0110);
        for (int k = 1; k <= 50; k++) sb.push_back('{ch: 2, val: 8'(75 + k)});
        sb.push_back('{ch: 2, val: 8'd125});
        run_sweeps(50, "s3_ramp");
        check("s3_busy_done", busy, 0);
        run_sweeps(1, "s3_hold_max");
        check("s3_ch1_hold", pos_out[15:8], 80);

        // Command held through a sweep waits for IDLE
        wait_tick();
        cyc(1);
        cmd_chan = 2'd3; cmd_pos = 8'd100; cmd_en = 1'b1; cmd_valid = 1'b1;
        lows = 0;
        while (cmd_ready === 1'b0 && lows < 10) begin
            check("s4_no_write", ch_en[3], 0);
            lows++;
            cyc(1);
        end
        check("s4_ready_low_cycles", lows, 4);
        check("s4_pending", ch_en[3], 0);
        cyc(1);
        cmd_valid = 1'b0;
        check("s4_accepted", ch_en, 4'b1110);
        for (int k = 1; k <= 25; k++) sb.push_back('{ch: 3, val: 8'(75 + k)});
        run_sweeps(25, "s4_ramp");
        check("s4_busy_done", busy, 0);

        // Disable mid-ramp forces home, then a command on the tick edge is used by that sweep
        send_cmd(2'd0, 8'd90, 1'b1);
        sb.push_back('{ch: 0, val: 8'd76});
        sb.push_back('{ch: 0, val: 8'd77});
        run_sweeps(2, "s5_ramp");
        send_cmd(2'd0, 8'd60, 1'b0);
        check("s5_en0", ch_en[0], 0);
        check("s5_home", pos_out[7:0], 75);
        sb.push_back('{ch: 0, val: 8'd75});
        run_sweeps(1, "s5_disabled_hold");
        wait_tick();
        cmd_chan = 2'd0; cmd_pos = 8'd74; cmd_en = 1'b1; cmd_valid = 1'b1;
        check("s5_ready_at_tick", cmd_ready, 1);
        cyc(1);
        cmd_valid = 1'b0;
        check("s5_en_at_tick", ch_en[0], 1);
        cyc(4);
        check("s5_tick_cmd_used", pos_out[7:0], 74);
        check("s5_err_sticky", cmd_err, 1);

        // Reset during a sweep
        check("s6_pre", pos_out[31:24], 100);
        wait_tick();
        cyc(1);
        check("s6_in_sweep", cmd_ready, 0);
        rst = 1'b1;
        cyc(1);
        check("s6_pos", pos_out, 32'h4B4B_4B4B);
        check("s6_en", ch_en, 0);
        check("s6_busy", busy, 0);
        check("s6_ready", cmd_ready, 0);
        check("s6_tick", frame_tick, 0);
        check("s6_err", cmd_err, 0);
        rst = 1'b0;
        cyc(1);
        sb.push_back('{ch: 3, val: 8'd75});
        sb.push_back('{ch: 3, val: 8'd75});
        run_sweeps(2, "s6_no_ramp");
        send_cmd(2'd3, 8'd77, 1'b1);
        sb.push_back('{ch: 3, val: 8'd76});
        sb.push_back('{ch: 3, val: 8'd77});
        run_sweeps(2, "s6_resume");
        check("s6_sb_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: observed no end of test, expected finish");
        $fatal(1, "timeout");
    end

endmodule
